// File: rtl/kart_pkg.sv
// Shared types and constants for the kart motion engine.
// Holds the FSM state enum, fixed-point widths and the heading wrap helper.
package kart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPEED,
        STEER,
        TRIG,
        MOVE,
        COMMIT
    } kart_state_t;

    localparam int POS_FRAC  = 4;
    localparam int TRIG_FRAC = 7;

    typedef logic [10:0]        coord_t;
    typedef logic [8:0]         heading_t;
    typedef logic [14:0]        pos_t;
    typedef logic signed [8:0]  trig_t;
    typedef logic signed [16:0] pos_tmp_t;

    // Add a small signed step to a heading and wrap into 0..359.
    function automatic heading_t heading_add(heading_t d,
                                             logic signed [9:0] delta);
        logic signed [10:0] s;
        s = $signed({2'b00, d}) + 11'(delta);
        if (s < 0) begin
            s = s + 11'sd360;
        end else if (s >= 11'sd360) begin
            s = s - 11'sd360;
        end
        return s[8:0];
    endfunction

endpackage

// File: rtl/kart_physics_trig_lut.sv
// Registered cos/sin lookup for a heading in degrees, signed Q1.7.
// Ports: clk_in, rst_in, angle_in (0..359), cos_out, sin_out (1-cycle latency).
module trig_lut
    import kart_pkg::*;
(
    input  logic     clk_in,
    input  logic     rst_in,
    input  heading_t angle_in,
    output trig_t    cos_out,
    output trig_t    sin_out
);

    // round(128 * sin(k deg)) for k = 0..90
    localparam logic [7:0] SIN_TAB [0:90] = '{
        8'd0,   8'd2,   8'd4,   8'd7,   8'd9,   8'd11,  8'd13,  8'd16,
        8'd18,  8'd20,  8'd22,  8'd24,  8'd27,  8'd29,  8'd31,  8'd33,
        8'd35,  8'd37,  8'd40,  8'd42,  8'd44,  8'd46,  8'd48,  8'd50,
        8'd52,  8'd54,  8'd56,  8'd58,  8'd60,  8'd62,  8'd64,  8'd66,
        8'd68,  8'd70,  8'd72,  8'd73,  8'd75,  8'd77,  8'd79,  8'd81,
        8'd82,  8'd84,  8'd86,  8'd87,  8'd89,  8'd91,  8'd92,  8'd94,
        8'd95,  8'd97,  8'd98,  8'd99,  8'd101, 8'd102, 8'd104, 8'd105,
        8'd106, 8'd107, 8'd109, 8'd110, 8'd111, 8'd112, 8'd113, 8'd114,
        8'd115, 8'd116, 8'd117, 8'd118, 8'd119, 8'd119, 8'd120, 8'd121,
        8'd122, 8'd122, 8'd123, 8'd124, 8'd124, 8'd125, 8'd125, 8'd126,
        8'd126, 8'd126, 8'd127, 8'd127, 8'd127, 8'd128, 8'd128, 8'd128,
        8'd128, 8'd128, 8'd128
    };

    // Fold a full-circle angle onto the 0..90 quarter table.
    function automatic trig_t sin_fold(heading_t a);
        logic [8:0] t;
        logic       neg;
        trig_t      mag;
        t   = a;
        neg = 1'b0;
        if (a <= 9'd90) begin
            t = a;
        end else if (a <= 9'd180) begin
            t = 9'd180 - a;
        end else if (a <= 9'd270) begin
            t   = a - 9'd180;
            neg = 1'b1;
        end else begin
            t   = 9'd360 - a;
            neg = 1'b1;
        end
        mag = $signed({1'b0, SIN_TAB[t[6:0]]});
        return neg ? -mag : mag;
    endfunction

    heading_t cos_angle;
    trig_t    cos_d, cos_q;
    trig_t    sin_d, sin_q;

    // cos(a) = sin(a + 90)
    always_comb begin
        cos_angle = (angle_in >= 9'd270) ? angle_in - 9'd270
                                         : angle_in + 9'd90;
        cos_d = sin_fold(cos_angle);
        sin_d = sin_fold(angle_in);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cos_q <= '0;
            sin_q <= '0;
        end else begin
            cos_q <= cos_d;
            sin_q <= sin_d;
        end
    end

    assign cos_out = cos_q;
    assign sin_out = sin_q;

endmodule

// File: rtl/kart_physics.sv
// Per-frame kart motion engine: speed, steering, trig, move, clamp, commit.
// Ports: clk_in, rst_in, frame_tick_in, accel/brake/left/right_in in;
//        x_out, y_out, direction_out, speed_out, update_valid_out out.
module kart_physics
    import kart_pkg::*;
#(
    parameter int INIT_X    = 191,
    parameter int INIT_Y    = 191,
    parameter int INIT_DIR  = 270,
    parameter int TRACK_MAX = 1023,
    parameter int MAX_SPEED = 64,
    parameter int ACCEL     = 4,
    parameter int BRAKE     = 8,
    parameter int DRAG      = 1,
    parameter int TURN_RATE = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_tick_in,
    input  logic        accel_in,
    input  logic        brake_in,
    input  logic        left_in,
    input  logic        right_in,
    output logic [10:0] x_out,
    output logic [10:0] y_out,
    output logic [8:0]  direction_out,
    output logic [7:0]  speed_out,
    output logic        update_valid_out
);

    localparam pos_t INIT_PX = 15'(INIT_X << POS_FRAC);
    localparam pos_t INIT_PY = 15'(INIT_Y << POS_FRAC);
    localparam pos_t POS_WALL = 15'(TRACK_MAX << POS_FRAC);
    localparam pos_tmp_t POS_LIM =
        17'((TRACK_MAX << POS_FRAC) + (1 << POS_FRAC) - 1);

    kart_state_t state_q, state_d;
    logic        pending_q, pending_d;
    logic [7:0]  speed_q, speed_d;
    heading_t    dir_q, dir_d;
    pos_t        pos_x_q, pos_x_d;
    pos_t        pos_y_q, pos_y_d;
    pos_tmp_t    tmp_x_q, tmp_x_d;
    pos_tmp_t    tmp_y_q, tmp_y_d;
    coord_t      x_out_q, x_out_d;
    coord_t      y_out_q, y_out_d;
    heading_t    dir_out_q, dir_out_d;
    logic [7:0]  speed_out_q, speed_out_d;
    logic        valid_q, valid_d;

    trig_t              cos_v, sin_v;
    logic signed [17:0] prod_x, prod_y;
    logic signed [16:0] dx, dy;
    logic [8:0]         spd_up;
    logic signed [9:0]  turn_delta;
    pos_t               clamp_x, clamp_y;
    logic               hit_x, hit_y;

    trig_lut u_trig (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .angle_in (dir_q),
        .cos_out  (cos_v),
        .sin_out  (sin_v)
    );

    // Arithmetic shift floors the step toward minus infinity.
    assign prod_x = $signed({1'b0, speed_q}) * cos_v;
    assign prod_y = $signed({1'b0, speed_q}) * sin_v;
    assign dx     = 17'(prod_x >>> TRIG_FRAC);
    assign dy     = 17'(prod_y >>> TRIG_FRAC);

    assign spd_up     = {1'b0, speed_q} + 9'(ACCEL);
    assign turn_delta = right_in ? 10'(TURN_RATE) : -10'(TURN_RATE);

    // Wall clamp on the staged move results.
    always_comb begin
        hit_x   = 1'b0;
        clamp_x = tmp_x_q[14:0];
        if (tmp_x_q < 0) begin
            hit_x   = 1'b1;
            clamp_x = '0;
        end else if (tmp_x_q > POS_LIM) begin
            hit_x   = 1'b1;
            clamp_x = POS_WALL;
        end
        hit_y   = 1'b0;
        clamp_y = tmp_y_q[14:0];
        if (tmp_y_q < 0) begin
            hit_y   = 1'b1;
            clamp_y = '0;
        end else if (tmp_y_q > POS_LIM) begin
            hit_y   = 1'b1;
            clamp_y = POS_WALL;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        speed_d     = speed_q;
        dir_d       = dir_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        tmp_x_d     = tmp_x_q;
        tmp_y_d     = tmp_y_q;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        dir_out_d   = dir_out_q;
        speed_out_d = speed_out_q;
        valid_d     = 1'b0;

        // One-deep pending: extra ticks while busy collapse into one.
        if (frame_tick_in && state_q != IDLE) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (frame_tick_in) begin
                    state_d = SPEED;
                end
            end
            SPEED: begin
                if (brake_in) begin
                    speed_d = (speed_q > 8'(BRAKE)) ? speed_q - 8'(BRAKE)
                                                    : 8'd0;
                end else if (accel_in) begin
                    speed_d = (spd_up > 9'(MAX_SPEED)) ? 8'(MAX_SPEED)
                                                       : spd_up[7:0];
                end else begin
                    speed_d = (speed_q > 8'(DRAG)) ? speed_q - 8'(DRAG)
                                                   : 8'd0;
                end
                state_d = STEER;
            end
            STEER: begin
                if (speed_q != 8'd0 && (left_in ^ right_in)) begin
                    dir_d = heading_add(dir_q, turn_delta);
                end
                state_d = TRIG;
            end
            TRIG: begin
                state_d = MOVE;
            end
            MOVE: begin
                tmp_x_d = $signed({2'b00, pos_x_q}) + dx;
                tmp_y_d = $signed({2'b00, pos_y_q}) + dy;
                state_d = COMMIT;
            end
            COMMIT: begin
                pos_x_d     = clamp_x;
                pos_y_d     = clamp_y;
                if (hit_x || hit_y) begin
                    speed_d = 8'd0;
                end
                x_out_d     = clamp_x[14:POS_FRAC];
                y_out_d     = clamp_y[14:POS_FRAC];
                dir_out_d   = dir_q;
                speed_out_d = (hit_x || hit_y) ? 8'd0 : speed_q;
                valid_d     = 1'b1;
                if (pending_q || frame_tick_in) begin
                    pending_d = 1'b0;
                    state_d   = SPEED;
                end else begin
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            speed_q     <= '0;
            dir_q       <= 9'(INIT_DIR);
            pos_x_q     <= INIT_PX;
            pos_y_q     <= INIT_PY;
            tmp_x_q     <= '0;
            tmp_y_q     <= '0;
            x_out_q     <= 11'(INIT_X);
            y_out_q     <= 11'(INIT_Y);
            dir_out_q   <= 9'(INIT_DIR);
            speed_out_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            speed_q     <= speed_d;
            dir_q       <= dir_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            tmp_x_q     <= tmp_x_d;
            tmp_y_q     <= tmp_y_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            dir_out_q   <= dir_out_d;
            speed_out_q <= speed_out_d;
            valid_q     <= valid_d;
        end
    end

    assign x_out            = x_out_q;
    assign y_out            = y_out_q;
    assign direction_out    = dir_out_q;
    assign speed_out        = speed_out_q;
    assign update_valid_out = valid_q;

endmodule

// File: tb/tb_kart_physics.sv
// Directed bench for kart_physics: reset, accel/brake/drag, steering wrap,
// wall clamps and tick queuing, across four differently-parameterised karts.
module tb_kart_physics;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [3:0] acc, brk, lft, rgt;

    logic [10:0] xo  [4];
    logic [10:0] yo  [4];
    logic [8:0]  dir [4];
    logic [7:0]  spd [4];
    logic        vld [4];

    int n_checks = 0;
    int n_errors = 0;

    kart_physics u_dut (
        .clk_in(clk), .rst_in(rst), .frame_tick_in(tick),
        .accel_in(acc[0]), .brake_in(brk[0]),
        .left_in(lft[0]), .right_in(rgt[0]),
        .x_out(xo[0]), .y_out(yo[0]), .direction_out(dir[0]),
        .speed_out(spd[0]), .update_valid_out(vld[0])
    );

    kart_physics #(.INIT_DIR(358)) u_wrap (
        .clk_in(clk), .rst_in(rst), .frame_tick_in(tick),
        .accel_in(acc[1]), .brake_in(brk[1]),
        .left_in(lft[1]), .right_in(rgt[1]),
        .x_out(xo[1]), .y_out(yo[1]), .direction_out(dir[1]),
        .speed_out(spd[1]), .update_valid_out(vld[1])
    );

    kart_physics #(.INIT_Y(1)) u_wall_y (
        .clk_in(clk), .rst_in(rst), .frame_tick_in(tick),
        .accel_in(acc[2]), .brake_in(brk[2]),
        .left_in(lft[2]), .right_in(rgt[2]),
        .x_out(xo[2]), .y_out(yo[2]), .direction_out(dir[2]),
        .speed_out(spd[2]), .update_valid_out(vld[2])
    );

    kart_physics #(.INIT_X(1023), .INIT_DIR(0)) u_wall_x (
        .clk_in(clk), .rst_in(rst), .frame_tick_in(tick),
        .accel_in(acc[3]), .brake_in(brk[3]),
        .left_in(lft[3]), .right_in(rgt[3]),
        .x_out(xo[3]), .y_out(yo[3]), .direction_out(dir[3]),
        .speed_out(spd[3]), .update_valid_out(vld[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout, got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse one tick, then expect instance idx to commit 5 edges later
    // with a single-cycle valid pulse.
    task automatic tick_frame(input int idx);
        int n;
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        n = 0;
        while (!vld[idx] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, 5);
        @(posedge clk);
        #1;
        check("valid_one_cycle", int'(vld[idx]), 0);
    endtask

    initial begin
        int seen;
        rst  = 1'b1;
        tick = 1'b0;
        acc  = '0;
        brk  = '0;
        lft  = '0;
        rgt  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_x", int'(xo[0]), 191);
        check("rst_y", int'(yo[0]), 191);
        check("rst_dir", int'(dir[0]), 270);
        check("rst_speed", int'(spd[0]), 0);
        check("rst_valid", int'(vld[0]), 0);
        check("rst_dir_wrap", int'(dir[1]), 358);
        check("rst_x_wall", int'(xo[3]), 1023);

        // Reset asserted mid-update aborts the frame.
        acc[0] = 1'b1;
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) rst = 1'b0;
            if (vld[0]) seen++;
        end
        check("abort_no_valid", seen, 0);
        check("abort_y", int'(yo[0]), 191);
        check("abort_speed", int'(spd[0]), 0);

        // Accelerate straight up from dir 270.
        tick_frame(0);
        check("acc1_speed", int'(spd[0]), 4);
        check("acc1_y", int'(yo[0]), 190);
        tick_frame(0);
        check("acc2_speed", int'(spd[0]), 8);
        check("acc2_y", int'(yo[0]), 190);
        tick_frame(0);
        check("acc3_speed", int'(spd[0]), 12);
        check("acc3_y", int'(yo[0]), 189);
        check("acc3_x", int'(xo[0]), 191);

        // Brake beats accel, then drag down to zero.
        brk[0] = 1'b1;
        tick_frame(0);
        check("brake_speed", int'(spd[0]), 4);
        acc[0] = 1'b0;
        brk[0] = 1'b0;
        tick_frame(0);
        check("drag_speed", int'(spd[0]), 3);
        for (int i = 0; i < 3; i++) tick_frame(0);
        check("drag_zero", int'(spd[0]), 0);
        tick_frame(0);
        check("stay_zero", int'(spd[0]), 0);
        check("dir_unsteered", int'(dir[0]), 270);

        // Heading wraps through 0 in both directions.
        acc[1] = 1'b1;
        rgt[1] = 1'b1;
        tick_frame(1);
        check("wrap_right_dir", int'(dir[1]), 1);
        check("wrap_right_spd", int'(spd[1]), 4);
        acc[1] = 1'b0;
        rgt[1] = 1'b0;
        lft[1] = 1'b1;
        tick_frame(1);
        check("wrap_left_dir", int'(dir[1]), 358);
        check("wrap_left_spd", int'(spd[1]), 3);
        lft[1] = 1'b0;
        brk[1] = 1'b1;
        rgt[1] = 1'b1;
        tick_frame(1);
        check("stopped_spd", int'(spd[1]), 0);
        check("stopped_dir", int'(dir[1]), 358);
        brk[1] = 1'b0;
        rgt[1] = 1'b0;

        // Top wall: internal y 16 -> 12 -> 4 -> clamp at 0.
        acc[2] = 1'b1;
        tick_frame(2);
        check("wy1_speed", int'(spd[2]), 4);
        check("wy1_y", int'(yo[2]), 0);
        tick_frame(2);
        check("wy2_speed", int'(spd[2]), 8);
        tick_frame(2);
        check("wy3_speed", int'(spd[2]), 0);
        check("wy3_y", int'(yo[2]), 0);
        check("wy3_x", int'(xo[2]), 191);
        acc[2] = 1'b0;

        // Right wall: 16368 -> 16372 -> 16380 -> clamp at 16368.
        acc[3] = 1'b1;
        tick_frame(3);
        check("wx1_speed", int'(spd[3]), 4);
        check("wx1_x", int'(xo[3]), 1023);
        tick_frame(3);
        check("wx2_speed", int'(spd[3]), 8);
        tick_frame(3);
        check("wx3_speed", int'(spd[3]), 0);
        check("wx3_x", int'(xo[3]), 1023);
        check("wx3_y", int'(yo[3]), 191);
        acc[3] = 1'b0;

        // Ticks at N, N+2, N+3: commits at N+5 and N+10 only.
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        seen = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            tick = (k == 2 || k == 3);
            @(posedge clk);
            #1;
            if (vld[0] != (k == 5 || k == 10)) begin
                check($sformatf("pend_valid_k%0d", k), int'(vld[0]),
                      int'(k == 5 || k == 10));
            end
            if (vld[0]) seen++;
        end
        tick = 1'b0;
        check("pend_pulses", seen, 2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
